// File: rtl/otter_io_pkg.sv
// ============================================================================
// otter_io_pkg : shared constants and destination select encoding for the
//                1:4 store/IO steering path.
// Revision     : 1.0
// ============================================================================
`default_nettype none

package otter_io_pkg;

    localparam int DEMUX_PORTS = 4;

    typedef enum logic [1:0] {
        DST_0 = 2'd0,
        DST_1 = 2'd1,
        DST_2 = 2'd2,
        DST_3 = 2'd3
    } dst_e;

endpackage

`default_nettype wire

// File: rtl/demux_fifo.sv
// ============================================================================
// demux_fifo : single-clock FIFO with occupancy count, registered head word.
// Revision   : 1.0
// ============================================================================
`default_nettype none

module demux_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    // Guards make an overflow push or an empty pop a no-op.
    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/demux1_4_fifo.sv
// ============================================================================
// demux1_4_fifo : steers one valid/ready stream into four per-destination
//                 FIFOs, each drained by its own valid/ready consumer.
// Revision      : 1.0
// ============================================================================
`default_nettype none

module demux1_4_fifo
    import otter_io_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [1:0]                   sel,
    input  logic [WIDTH-1:0]             in_data,
    output logic [DEMUX_PORTS-1:0]       out_valid,
    input  logic [DEMUX_PORTS-1:0]       out_ready,
    output logic [DEMUX_PORTS*WIDTH-1:0] out_data,
    output logic [DEMUX_PORTS*CNT_W-1:0] out_count,
    output logic                         idle
);

    logic [DEMUX_PORTS-1:0] push;
    logic [DEMUX_PORTS-1:0] full;
    logic [DEMUX_PORTS-1:0] empty;
    logic [CNT_W-1:0]       count [DEMUX_PORTS];
    logic [WIDTH-1:0]       head  [DEMUX_PORTS];

    // Ready depends only on sel and FIFO state, so a full FIFO never passes through.
    assign in_ready = !full[sel];
    assign idle     = &(~out_valid);

    for (genvar i = 0; i < DEMUX_PORTS; i++) begin : g_port
        assign push[i] = in_valid && in_ready && (dst_e'(sel) == dst_e'(i));

        demux_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH),
            .CNT_W (CNT_W)
        ) u_fifo (
            .CLK     (CLK),
            .RST     (RST),
            .push    (push[i]),
            .pop     (out_ready[i]),
            .wr_data (in_data),
            .full    (full[i]),
            .empty   (empty[i]),
            .count   (count[i]),
            .head    (head[i])
        );

        assign out_valid[i]                  = !empty[i];
        assign out_data[i*WIDTH +: WIDTH]    = head[i];
        assign out_count[i*CNT_W +: CNT_W]   = count[i];
    end

endmodule

`default_nettype wire

// File: tb/tb_demux1_4_fifo.sv
// ============================================================================
// tb_demux1_4_fifo : scoreboard bench for the 1:4 steering FIFO block.
// Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_demux1_4_fifo;

    localparam int WIDTH = 32;
    localparam int DEPTH = 2;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic               CLK;
    logic               RST;
    logic               in_valid;
    logic               in_ready;
    logic [1:0]         sel;
    logic [WIDTH-1:0]   in_data;
    logic [3:0]         out_valid;
    logic [3:0]         out_ready;
    logic [4*WIDTH-1:0] out_data;
    logic [4*CNT_W-1:0] out_count;
    logic               idle;

    int n_cmp = 0;
    int n_err = 0;
    bit mon_en = 0;

    logic [WIDTH-1:0] sb [4][$];

    demux1_4_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .idle      (idle)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, obs, exp, $time);
        end
    endtask

    // Expectations are taken from the pre-edge model, then the model takes the edge.
    always @(negedge CLK) begin
        if (!RST && mon_en) begin
            bit exp_rdy;
            bit any;
            exp_rdy = (sb[sel].size() != DEPTH);
            any = 1'b0;
            for (int i = 0; i < 4; i++) begin
                check($sformatf("out_valid%0d", i), 64'(out_valid[i]), 64'(sb[i].size() != 0));
                check($sformatf("out_count%0d", i), 64'(out_count[i*CNT_W +: CNT_W]), 64'(sb[i].size()));
                if (sb[i].size() != 0) begin
                    any = 1'b1;
                    check($sformatf("out_data%0d", i), 64'(out_data[i*WIDTH +: WIDTH]), 64'(sb[i][0]));
                end
            end
            check("in_ready", 64'(in_ready), 64'(exp_rdy));
            check("idle", 64'(idle), 64'(!any));
            for (int i = 0; i < 4; i++) begin
                if (sb[i].size() != 0 && out_ready[i]) void'(sb[i].pop_front());
            end
            if (in_valid && exp_rdy) sb[sel].push_back(in_data);
        end
    end

    task automatic drive(input bit v, input logic [1:0] s, input logic [WIDTH-1:0] d,
                         input logic [3:0] ordy);
        @(posedge CLK);
        #1;
        in_valid  = v;
        sel       = s;
        in_data   = d;
        out_ready = ordy;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 64'(out_valid), 64'h0);
        check({tag, "_idle"},  64'(idle),      64'h1);
        check({tag, "_ready"}, 64'(in_ready),  64'h1);
        check({tag, "_count"}, 64'(out_count), 64'h0);
        check({tag, "_data"},  64'(out_data[63:0]),   64'h0);
        check({tag, "_datah"}, 64'(out_data[127:64]), 64'h0);
    endtask

    task automatic drain(input string tag);
        int cyc;
        drive(1'b0, 2'd0, '0, 4'hF);
        cyc = 0;
        while ((sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size()) != 0 && cyc < 20) begin
            @(posedge CLK);
            cyc++;
        end
        if (cyc >= 20) check({tag, "_drain_timeout"}, 64'h0, 64'h1);
        drive(1'b0, 2'd0, '0, 4'h0);
    endtask

    // Reset lands mid-cycle so the async clear is observed before the next edge.
    task automatic async_reset(input string tag);
        @(posedge CLK);
        #3;
        RST = 1'b1;
        #1;
        check_reset_outputs(tag);
        for (int i = 0; i < 4; i++) sb[i].delete();
        in_valid  = 1'b0;
        out_ready = 4'h0;
        @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    initial begin
        RST = 1'b1;
        in_valid = 1'b0;
        sel = 2'd0;
        in_data = '0;
        out_ready = 4'h0;
        #1;
        check_reset_outputs("rst_init");
        @(posedge CLK);
        #1;
        RST = 1'b0;
        mon_en = 1'b1;

        // Single route to sel 2, then drain it.
        drive(1'b1, 2'd2, 32'hDEADBEEF, 4'h0);
        drive(1'b0, 2'd2, '0, 4'h0);
        drive(1'b0, 2'd2, '0, 4'b0100);
        drive(1'b0, 2'd2, '0, 4'h0);

        // Fill FIFO1, confirm backpressure is per-sel.
        drive(1'b1, 2'd1, 32'h1, 4'h0);
        drive(1'b1, 2'd1, 32'h2, 4'h0);
        drive(1'b0, 2'd1, '0, 4'h0);
        drive(1'b1, 2'd3, 32'h3, 4'h0);

        // Full FIFO1 with simultaneous pop: push held off one cycle.
        drive(1'b1, 2'd1, 32'h4, 4'b0010);
        drive(1'b1, 2'd1, 32'h4, 4'h0);
        drive(1'b0, 2'd1, '0, 4'h0);
        drain("fill");

        // Steady push/pop on FIFO0 with occupancy 1 across pointer wraps.
        drive(1'b1, 2'd0, 32'h100, 4'h0);
        for (int k = 0; k < 20; k++) begin
            drive(1'b1, 2'd0, 32'hA0 + 32'(k), 4'b0001);
        end
        drain("steady");

        // Async reset with three FIFOs occupied.
        drive(1'b1, 2'd0, 32'h11, 4'h0);
        drive(1'b1, 2'd1, 32'h22, 4'h0);
        drive(1'b1, 2'd2, 32'h33, 4'h0);
        drive(1'b0, 2'd0, '0, 4'h0);
        async_reset("rst_mid");
        drive(1'b1, 2'd3, 32'h55, 4'h0);
        drive(1'b0, 2'd3, '0, 4'h0);
        drive(1'b0, 2'd3, '0, 4'h0);
        drain("post_rst");

        // Random traffic; model decides acceptance and pops.
        for (int k = 0; k < 60; k++) begin
            drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom,
                  4'($urandom_range(0, 15)));
        end
        drain("rand");

        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
